// File: rtl/snn_layer_tm_if.sv
// Handshake, parameter-load, weight-write and counter-readout bundle for snn_layer_tm.
// The DUT uses the slave modport and the driver side uses the master modport.
interface snn_layer_tm_if #(
    parameter int WIDTH    = 16,
    parameter int N_INPUT  = 4,
    parameter int N_OUTPUT = 3
);
    localparam int IW = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
    localparam int OW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;

    logic                    load_params;
    logic        [WIDTH-1:0] new_V_threshold;
    logic        [WIDTH-1:0] new_leak_factor;
    logic        [WIDTH-1:0] new_refr_period;
    logic signed [WIDTH-1:0] new_V_max;
    logic signed [WIDTH-1:0] new_V_min;
    logic                    w_we;
    logic [IW-1:0]           w_addr_in;
    logic [OW-1:0]           w_addr_out;
    logic signed [WIDTH-1:0] w_data;
    logic                    step_valid;
    logic                    step_ready;
    logic [N_INPUT-1:0]      in_spikes;
    logic                    out_valid;
    logic [N_OUTPUT-1:0]     out_spikes;
    logic [OW-1:0]           cnt_sel;
    logic                    cnt_clr;
    logic [15:0]             cnt_out;

    modport slave (
        input  load_params, new_V_threshold, new_leak_factor, new_refr_period,
               new_V_max, new_V_min, w_we, w_addr_in, w_addr_out, w_data,
               step_valid, in_spikes, cnt_sel, cnt_clr,
        output step_ready, out_valid, out_spikes, cnt_out
    );

    modport master (
        output load_params, new_V_threshold, new_leak_factor, new_refr_period,
               new_V_max, new_V_min, w_we, w_addr_in, w_addr_out, w_data,
               step_valid, in_spikes, cnt_sel, cnt_clr,
        input  step_ready, out_valid, out_spikes, cnt_out
    );
endinterface

// File: rtl/snn_layer_tm.sv
// Time-multiplexed layer of LIF neurons: one synapse accumulated per cycle, one neuron updated per pass.
// Optional per-neuron saturating spike counters are enabled by defining SNN_SPIKE_COUNT_EN.
module snn_layer_tm #(
    parameter int WIDTH         = 16,
    parameter int N_INPUT       = 4,
    parameter int N_OUTPUT      = 3,
    parameter int DEF_THRESHOLD = 1000,
    parameter int DEF_LEAK      = 50,
    parameter int DEF_REFR      = 5,
    parameter int DEF_VMAX      = 32767,
    parameter int DEF_VMIN      = -32768
) (
    input logic           clk,
    input logic           rst,
    snn_layer_tm_if.slave bus
);
    localparam int IW = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1;
    localparam int OW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam int AW = WIDTH + IW + 1;
    localparam int EW = AW + 2;

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_i;
    logic [OW-1:0]           r_j;
    logic [N_INPUT-1:0]      r_spk;
    logic signed [AW-1:0]    r_acc;
    logic signed [WIDTH-1:0] r_w    [N_INPUT][N_OUTPUT];
    logic signed [WIDTH-1:0] r_v    [N_OUTPUT];
    logic        [WIDTH-1:0] r_refr [N_OUTPUT];
    logic        [WIDTH-1:0] r_thr, r_leak, r_refr_p, r_sh_thr, r_sh_leak, r_sh_refr_p;
    logic signed [WIDTH-1:0] r_vmax, r_vmin, r_sh_vmax, r_sh_vmin;
    logic                    r_sh_pend;
    logic                    r_step_ready;
    logic                    r_out_valid;
    logic [N_OUTPUT-1:0]     r_out_spikes;
    logic [N_OUTPUT-1:0]     r_spk_res;

    logic signed [EW-1:0]    w_v, w_leak, w_dec, w_sum, w_clamp, w_vmax, w_vmin, w_thr;
    logic                    w_fire, w_hit;
    logic [N_OUTPUT-1:0]     w_res;

    // Leak toward zero, integrate, clamp; EW is wide enough that no step can overflow.
    always_comb begin
        w_v    = EW'(r_v[r_j]);
        w_leak = EW'(r_leak);
        w_vmax = EW'(r_vmax);
        w_vmin = EW'(r_vmin);
        w_thr  = EW'(r_thr);
        w_dec  = w_v;
        if (!w_v[EW-1] && (w_v != '0)) begin
            w_dec = w_v - w_leak;
            if (w_dec[EW-1]) w_dec = '0;
        end else if (w_v[EW-1]) begin
            w_dec = w_v + w_leak;
            if (!w_dec[EW-1] && (w_dec != '0)) w_dec = '0;
        end
        w_sum   = w_dec + EW'(r_acc);
        w_clamp = w_sum;
        if (w_sum > w_vmax) w_clamp = w_vmax;
        if (w_sum < w_vmin) w_clamp = w_vmin;
        w_fire  = (w_clamp >= w_thr);
        w_hit   = (r_refr[r_j] == '0) && w_fire;
        w_res   = r_spk_res;
        w_res[r_j] = w_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_i          <= '0;
            r_j          <= '0;
            r_spk        <= '0;
            r_acc        <= '0;
            r_thr        <= WIDTH'(DEF_THRESHOLD);
            r_leak       <= WIDTH'(DEF_LEAK);
            r_refr_p     <= WIDTH'(DEF_REFR);
            r_vmax       <= WIDTH'(DEF_VMAX);
            r_vmin       <= WIDTH'(DEF_VMIN);
            r_sh_thr     <= WIDTH'(DEF_THRESHOLD);
            r_sh_leak    <= WIDTH'(DEF_LEAK);
            r_sh_refr_p  <= WIDTH'(DEF_REFR);
            r_sh_vmax    <= WIDTH'(DEF_VMAX);
            r_sh_vmin    <= WIDTH'(DEF_VMIN);
            r_sh_pend    <= 1'b0;
            r_step_ready <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_spikes <= '0;
            r_spk_res    <= '0;
            for (int unsigned a = 0; a < N_INPUT; a++)
                for (int unsigned b = 0; b < N_OUTPUT; b++)
                    r_w[a][b] <= '0;
            for (int unsigned b = 0; b < N_OUTPUT; b++) begin
                r_v[b]    <= '0;
                r_refr[b] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (bus.load_params && (r_state == ACCUM || r_state == UPDATE)) begin
                r_sh_thr    <= bus.new_V_threshold;
                r_sh_leak   <= bus.new_leak_factor;
                r_sh_refr_p <= bus.new_refr_period;
                r_sh_vmax   <= bus.new_V_max;
                r_sh_vmin   <= bus.new_V_min;
                r_sh_pend   <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (bus.load_params) begin
                        r_thr    <= bus.new_V_threshold;
                        r_leak   <= bus.new_leak_factor;
                        r_refr_p <= bus.new_refr_period;
                        r_vmax   <= bus.new_V_max;
                        r_vmin   <= bus.new_V_min;
                    end
                    if (bus.w_we) r_w[bus.w_addr_in][bus.w_addr_out] <= bus.w_data;
                    if (bus.step_valid) begin
                        r_spk        <= bus.in_spikes;
                        r_i          <= '0;
                        r_j          <= '0;
                        r_acc        <= '0;
                        r_step_ready <= 1'b0;
                        r_state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (r_spk[r_i]) r_acc <= r_acc + AW'(r_w[r_i][r_j]);
                    if (r_i == IW'(N_INPUT - 1)) r_state <= UPDATE;
                    else                         r_i     <= r_i + 1'b1;
                end
                UPDATE: begin
                    if (r_refr[r_j] != '0) begin
                        r_refr[r_j] <= r_refr[r_j] - 1'b1;
                        r_v[r_j]    <= '0;
                    end else if (w_fire) begin
                        r_refr[r_j] <= r_refr_p;
                        r_v[r_j]    <= '0;
                    end else begin
                        r_v[r_j]    <= w_clamp[WIDTH-1:0];
                    end
                    r_spk_res <= w_res;
                    r_acc     <= '0;
                    if (r_j == OW'(N_OUTPUT - 1)) begin
                        r_out_spikes <= w_res;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_i     <= '0;
                        r_state <= ACCUM;
                    end
                end
                DONE: begin
                    // A strobe landing on the DONE cycle is newer than anything in the shadows.
                    if (bus.load_params) begin
                        r_thr    <= bus.new_V_threshold;
                        r_leak   <= bus.new_leak_factor;
                        r_refr_p <= bus.new_refr_period;
                        r_vmax   <= bus.new_V_max;
                        r_vmin   <= bus.new_V_min;
                    end else if (r_sh_pend) begin
                        r_thr    <= r_sh_thr;
                        r_leak   <= r_sh_leak;
                        r_refr_p <= r_sh_refr_p;
                        r_vmax   <= r_sh_vmax;
                        r_vmin   <= r_sh_vmin;
                    end
                    r_sh_pend    <= 1'b0;
                    r_step_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.step_ready = r_step_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_spikes = r_out_spikes;

`ifdef SNN_SPIKE_COUNT_EN
    logic [15:0] r_cnt [N_OUTPUT];
    logic [15:0] w_cnt;

    always_ff @(posedge clk) begin
        if (!rst || bus.cnt_clr) begin
            for (int unsigned b = 0; b < N_OUTPUT; b++) r_cnt[b] <= '0;
        end else if (r_state == UPDATE && w_hit && r_cnt[r_j] != '1) begin
            r_cnt[r_j] <= r_cnt[r_j] + 1'b1;
        end
    end

    always_comb begin
        w_cnt = '0;
        if (int'(bus.cnt_sel) < N_OUTPUT) w_cnt = r_cnt[bus.cnt_sel];
    end

    assign bus.cnt_out = w_cnt;
`else
    logic w_unused;
    assign w_unused    = ^{bus.cnt_sel, bus.cnt_clr};
    assign bus.cnt_out = '0;
`endif
endmodule

// File: tb/tb_snn_layer_tm.sv
// Scoreboard bench for snn_layer_tm: an integer LIF model predicts spikes and membranes per step.
// Counter checks follow SNN_SPIKE_COUNT_EN.
module tb_snn_layer_tm;
    localparam int WIDTH = 16;
    localparam int NI    = 4;
    localparam int NO    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    snn_layer_tm_if #(.WIDTH(WIDTH), .N_INPUT(NI), .N_OUTPUT(NO)) bus ();

    snn_layer_tm #(.WIDTH(WIDTH), .N_INPUT(NI), .N_OUTPUT(NO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int mw [NI][NO];
    int mv [NO];
    int mr [NO];
    int m_thr, m_leak, m_refr, m_vmax, m_vmin;
    int ld_thr, ld_leak, ld_refr, ld_vmax, ld_vmin;

    typedef struct packed {
        logic [NO-1:0]       spk;
        logic [NO-1:0][31:0] v;
    } exp_t;
    exp_t sb[$];

    task automatic ld_default();
        ld_thr = 1000; ld_leak = 50; ld_refr = 5; ld_vmax = 32767; ld_vmin = -32768;
    endtask

    task automatic model_apply();
        m_thr = ld_thr; m_leak = ld_leak; m_refr = ld_refr; m_vmax = ld_vmax; m_vmin = ld_vmin;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) for (int j = 0; j < NO; j++) mw[i][j] = 0;
        for (int j = 0; j < NO; j++) begin mv[j] = 0; mr[j] = 0; end
        ld_default();
        model_apply();
        sb.delete();
    endtask

    task automatic model_step(input logic [NI-1:0] spk, output exp_t e);
        e = '0;
        for (int j = 0; j < NO; j++) begin
            int acc;
            int v;
            acc = 0;
            for (int i = 0; i < NI; i++) if (spk[i]) acc += mw[i][j];
            if (mr[j] > 0) begin
                mr[j]--;
                mv[j] = 0;
            end else begin
                v = mv[j];
                if (v > 0)      v = (v > m_leak)  ? v - m_leak : 0;
                else if (v < 0) v = (-v > m_leak) ? v + m_leak : 0;
                v += acc;
                if (v > m_vmax) v = m_vmax;
                if (v < m_vmin) v = m_vmin;
                if (v >= m_thr) begin
                    e.spk[j] = 1'b1;
                    v = 0;
                    mr[j] = m_refr;
                end
                mv[j] = v;
            end
            e.v[j] = mv[j];
        end
    endtask

    task automatic drive_load();
        bus.load_params     = 1'b1;
        bus.new_V_threshold = 16'(ld_thr);
        bus.new_leak_factor = 16'(ld_leak);
        bus.new_refr_period = 16'(ld_refr);
        bus.new_V_max       = 16'(ld_vmax);
        bus.new_V_min       = 16'(ld_vmin);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic write_w(input int i, input int j, input int val);
        @(negedge clk);
        bus.w_we = 1'b1; bus.w_addr_in = 2'(i); bus.w_addr_out = 2'(j); bus.w_data = 16'(val);
        @(negedge clk);
        bus.w_we = 1'b0;
        mw[i][j] = val;
    endtask

    task automatic load_idle();
        @(negedge clk);
        drive_load();
        @(negedge clk);
        bus.load_params = 1'b0;
        model_apply();
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.step_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("ready_timeout", 0, 1);
    endtask

    // load_at: -1 none, 0 with the handshake, >0 that many cycles into the step
    task automatic do_step(input logic [NI-1:0] spk, input int load_at,
                           input bit wr_same, input int wi, input int wj, input int wv);
        int unsigned c0;
        bit seen, pend;
        exp_t e, x;
        wait_ready();
        bus.step_valid = 1'b1;
        bus.in_spikes  = spk;
        if (load_at == 0) begin drive_load(); model_apply(); end
        if (wr_same) begin
            bus.w_we = 1'b1; bus.w_addr_in = 2'(wi); bus.w_addr_out = 2'(wj); bus.w_data = 16'(wv);
            mw[wi][wj] = wv;
        end
        model_step(spk, e);
        sb.push_back(e);
        c0 = cyc;
        @(negedge clk);
        bus.step_valid = 1'b0; bus.load_params = 1'b0; bus.w_we = 1'b0; bus.in_spikes = ~spk;
        seen = 1'b0; pend = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                check_eq("latency", longint'(cyc - c0), 16);
                if (sb.size() == 0) check_eq("sb_empty", 0, 1);
                else begin
                    x = sb.pop_front();
                    check_eq("out_spikes", longint'(bus.out_spikes), longint'(x.spk));
                    for (int j = 0; j < NO; j++)
                        check_eq($sformatf("V%0d", j), longint'($signed(dut.r_v[j])),
                                 longint'($signed(x.v[j])));
                end
            end else begin
                if (k == 3) begin
                    bus.w_we = 1'b1; bus.w_addr_in = '0; bus.w_addr_out = '0; bus.w_data = 16'h1234;
                end
                if (load_at == k) begin drive_load(); pend = 1'b1; end
                @(negedge clk);
                bus.w_we = 1'b0; bus.load_params = 1'b0;
            end
        end
        if (!seen) check_eq("out_valid_timeout", 0, 1);
        if (pend) model_apply();
        @(negedge clk);
        check_eq("out_valid_pulse", longint'(bus.out_valid), 0);
        check_eq("ready_after_done", longint'(bus.step_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ov_seen;
        bus.load_params = 1'b0; bus.new_V_threshold = '0; bus.new_leak_factor = '0;
        bus.new_refr_period = '0; bus.new_V_max = '0; bus.new_V_min = '0;
        bus.w_we = 1'b0; bus.w_addr_in = '0; bus.w_addr_out = '0; bus.w_data = '0;
        bus.step_valid = 1'b0; bus.in_spikes = '0; bus.cnt_sel = '0; bus.cnt_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_step_ready", longint'(bus.step_ready), 1);
        check_eq("rst_out_valid",  longint'(bus.out_valid), 0);
        check_eq("rst_out_spikes", longint'(bus.out_spikes), 0);
        check_eq("rst_cnt_out",    longint'(bus.cnt_out), 0);
        rst = 1'b1;
        model_reset();

        // Integrate, fire, refractory, recover
        for (int j = 0; j < NO; j++) write_w(0, j, 500);
        for (int s = 1; s <= 9; s++) begin
            do_step(4'b0001, -1, 1'b0, 0, 0, 0);
            if (s == 3) check_eq("step3_all_fire", longint'(bus.out_spikes), 7);
        end

        // Negative drive clamps at V_min
        do_reset();
        write_w(1, 0, -1000);
        ld_default(); ld_vmin = -1500;
        load_idle();
        for (int s = 0; s < 3; s++) do_step(4'b0010, -1, 1'b0, 0, 0, 0);

        // Positive clamp at V_max below threshold
        do_reset();
        write_w(2, 1, 30000);
        ld_default(); ld_vmax = 20000; ld_thr = 25000;
        load_idle();
        for (int s = 0; s < 2; s++) do_step(4'b0100, -1, 1'b0, 0, 0, 0);

        // Busy-time load deferred to the next step
        do_reset();
        write_w(0, 0, 1100);
        write_w(0, 1, 600);
        ld_default(); ld_thr = 2000;
        do_step(4'b0001, 5, 1'b0, 0, 0, 0);
        check_eq("mid_load_old_thr", longint'(bus.out_spikes), 1);
        do_step(4'b0001, -1, 1'b0, 0, 0, 0);
        check_eq("mid_load_new_thr", longint'(bus.out_spikes), 0);

        // Load and weight write in the handshake cycle apply to that step
        do_reset();
        ld_default(); ld_thr = 400;
        do_step(4'b1000, 0, 1'b1, 3, 2, 450);
        check_eq("same_cycle_fire", longint'(bus.out_spikes), 4);

        // Reset mid-step aborts and discards the pending shadow load
        do_reset();
        write_w(0, 0, 1100);
        @(negedge clk);
        bus.step_valid = 1'b1; bus.in_spikes = 4'b0001;
        @(negedge clk);
        bus.step_valid = 1'b0;
        ov_seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (bus.out_valid) ov_seen = 1'b1;
            if (k == 3) begin ld_default(); ld_thr = 5000; drive_load(); end
            if (k == 7) rst = 1'b0;
            if (k == 9) rst = 1'b1;
            @(negedge clk);
            bus.load_params = 1'b0;
        end
        check_eq("abort_no_out_valid", longint'(ov_seen), 0);
        check_eq("abort_ready", longint'(bus.step_ready), 1);
        model_reset();
        write_w(0, 0, 1100);
        do_step(4'b0001, -1, 1'b0, 0, 0, 0);

        // Spike counters
        do_reset();
        ld_default(); ld_refr = 0;
        load_idle();
        write_w(0, 0, 1000);
        for (int s = 0; s < 3; s++) do_step(4'b0001, -1, 1'b0, 0, 0, 0);
        bus.cnt_sel = 2'd0;
        #1;
`ifdef SNN_SPIKE_COUNT_EN
        check_eq("cnt0_three", longint'(bus.cnt_out), 3);
        bus.cnt_sel = 2'd1;
        #1;
        check_eq("cnt1_zero", longint'(bus.cnt_out), 0);
        bus.cnt_sel = 2'd0;
        @(negedge clk);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        check_eq("cnt0_cleared", longint'(bus.cnt_out), 0);
`else
        check_eq("cnt_tied_zero", longint'(bus.cnt_out), 0);
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        check_eq("cnt_tied_zero_clr", longint'(bus.cnt_out), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
